// File: rtl/seq_mult_pkg.sv
// Shared constants for the iterative shift-add multiplier: FSM state codes
// and the default operand width.
package seq_mult_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/seq_mult_if.sv
// Request/result bus of the sequential multiplier, shared with the sequential
// divider so either unit can sit behind the same arithmetic front end.
interface seq_mult_if #(
    parameter int WIDTH = 8
);
    // Handshake: start is taken only while busy=0 and captures a_in/b_in on
    // that edge; busy stays high until the result cycle ends; valid pulses for
    // exactly one cycle with product, which then holds until the next accept.
    logic                   start;
    logic [WIDTH-1:0]       a_in;
    logic [WIDTH-1:0]       b_in;
    logic                   busy;
    logic                   valid;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, a_in, b_in,
        input  busy, valid, product
    );

    modport slave (
        input  start, a_in, b_in,
        output busy, valid, product
    );

endinterface

// File: rtl/seq_mult_dp.sv
// Datapath of the shift-add multiplier: operand registers, WIDTH+1-bit adder,
// combined {carry,acc,mq} right shifter, iteration counter and product register.
module seq_mult_dp
    import seq_mult_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_ld,
    input  logic                 i_step,
    input  logic                 i_cap,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_last,
    output logic                 o_zero_op,
    output logic [2*WIDTH-1:0]   o_product
);

    logic [WIDTH-1:0]    r_mcand;
    logic [WIDTH-1:0]    r_acc;
    logic [WIDTH-1:0]    r_mq;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*WIDTH-1:0]  r_product;

    logic [WIDTH:0]      w_sum;
    logic [2*WIDTH-1:0]  w_shifted;

    // The adder carry becomes the new acc MSB after the shift, so no bit is lost.
    assign w_sum     = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_mcand} : '0);
    assign w_shifted = {w_sum, r_mq[WIDTH-1:1]};

    assign o_last    = (r_cnt == CNT_W'(WIDTH - 1));
    assign o_zero_op = (i_a == '0) || (i_b == '0);
    assign o_product = r_product;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand   <= '0;
            r_acc     <= '0;
            r_mq      <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (i_ld) begin
            r_mcand   <= i_a;
            r_acc     <= '0;
            r_mq      <= i_b;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (i_step) begin
            r_acc <= w_shifted[2*WIDTH-1:WIDTH];
            r_mq  <= w_shifted[WIDTH-1:0];
            r_cnt <= r_cnt + CNT_W'(1);
            // Final iteration: publish the fully shifted result as it forms.
            if (i_cap) begin
                r_product <= w_shifted;
            end
        end
    end

endmodule

// File: rtl/seq_mult.sv
// Iterative unsigned multiplier top: IDLE/CALC/DONE control FSM around seq_mult_dp.
// Optional zero-operand shortcut enabled by defining SEQ_MULT_EARLY_EXIT_EN.
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    seq_mult_if.slave     bus,
    output logic [1:0]    o_dbg_state
);

`ifdef SEQ_MULT_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    state_t r_state;
    state_t w_next_state;
    logic   r_busy;
    logic   r_valid;
    logic   w_ld;
    logic   w_step;
    logic   w_cap;
    logic   w_last;
    logic   w_zero_op;

    // busy/valid are flopped from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != IDLE);
            r_valid <= (w_next_state == DONE);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next_state = (EARLY_EXIT && w_zero_op) ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_ld   = 1'b0;
        w_step = 1'b0;
        w_cap  = 1'b0;
        case (r_state)
            IDLE: w_ld = bus.start;
            CALC: begin
                w_step = 1'b1;
                w_cap  = w_last;
            end
            default: ;
        endcase
    end

    seq_mult_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk       (clk),
        .rst       (rst),
        .i_ld      (w_ld),
        .i_step    (w_step),
        .i_cap     (w_cap),
        .i_a       (bus.a_in),
        .i_b       (bus.b_in),
        .o_last    (w_last),
        .o_zero_op (w_zero_op),
        .o_product (bus.product)
    );

    assign bus.busy    = r_busy;
    assign bus.valid   = r_valid;
    assign o_dbg_state = r_state;

endmodule
